axi_lite_master: RTL and testbench

AXI4-Lite initiator that turns a simple one-command/one-response request interface into AXI4-Lite master channel traffic. It is the counterpart of the `top_axi_*` AXI4-Lite slave port on `axi_slave`, and its `m_axi_*` outputs connect to that port directly. It allows one outstanding transaction, and it counts error responses for software visibility.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_master.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the
// master sequencing state enum.
package axi_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one outstanding command, registered channel
// outputs and a saturating count of non-OKAY responses.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [2:0]                prot_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      wr_q;
    logic                      aw_ok;
    logic                      w_ok;
    logic                      err_hit;

    assign cmd_ready    = (state == IDLE);
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = prot_q;
    assign m_axi_arprot = prot_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;

    // A channel is finished once its valid has dropped or handshakes now.
    assign aw_ok = !m_axi_awvalid || m_axi_awready;
    assign w_ok  = !m_axi_wvalid || m_axi_wready;

    always_comb begin
        err_hit = 1'b0;
        if (state == WR_RESP && m_axi_bvalid && m_axi_bresp != OKAY)
            err_hit = 1'b1;
        if (state == RD_RESP && m_axi_rvalid && m_axi_rresp != OKAY)
            err_hit = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            prot_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wr_q          <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            err_count     <= '0;
        end else begin
            if (err_hit && err_count != '1)
                err_count <= err_count + 1'b1;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        prot_q  <= cmd_prot;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        wr_q    <= cmd_write;
                        if (cmd_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (m_axi_awready)
                        m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)
                        m_axi_wvalid <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= wr_q;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        state        <= DONE;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= wr_q;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master with a stall-configurable
// slave model and a narrow-counter second instance.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    logic        x2_cmd_ready, x2_rsp_valid, x2_rsp_write;
    logic [31:0] x2_rsp_rdata, x2_awaddr, x2_wdata, x2_araddr;
    logic [1:0]  x2_rsp_resp, err_count2;
    logic [2:0]  x2_awprot, x2_arprot;
    logic [3:0]  x2_wstrb;
    logic        x2_awvalid, x2_wvalid, x2_bready, x2_arvalid, x2_rready;

    always #5 clk = ~clk;

    axi_lite_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .err_count(err_count),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    axi_lite_master #(.ERR_CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(x2_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_prot(cmd_prot),
        .rsp_valid(x2_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(x2_rsp_write), .rsp_rdata(x2_rsp_rdata),
        .rsp_resp(x2_rsp_resp), .err_count(err_count2),
        .m_axi_awaddr(x2_awaddr), .m_axi_awprot(x2_awprot),
        .m_axi_awvalid(x2_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(x2_wdata), .m_axi_wstrb(x2_wstrb),
        .m_axi_wvalid(x2_wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(x2_bready),
        .m_axi_araddr(x2_araddr), .m_axi_arprot(x2_arprot),
        .m_axi_arvalid(x2_arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(x2_rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          err;
        int          err2;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_err = 0;
    int exp_err2 = 0;

    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    int b_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = OKAY;
    logic [1:0]  r_resp_cfg = OKAY;
    logic [31:0] r_data_cfg = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Slave model: readies/valids driven just after each rising edge.
    initial begin
        int awc, wc, arc, bc, rc;
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            if (awvalid) begin awready = (awc >= aw_delay); awc++; end
            else begin awready = 0; awc = 0; end
            if (wvalid) begin wready = (wc >= w_delay); wc++; end
            else begin wready = 0; wc = 0; end
            if (arvalid) begin arready = (arc >= ar_delay); arc++; end
            else begin arready = 0; arc = 0; end
            if (bready) begin
                bvalid = (bc >= b_delay); bresp = b_resp_cfg; bc++;
            end else begin
                bvalid = 0; bresp = 0; bc = 0;
            end
            if (rready) begin
                rvalid = (rc >= r_delay); rresp = r_resp_cfg;
                rdata = r_data_cfg; rc++;
            end else begin
                rvalid = 0; rresp = 0; rdata = 0; rc = 0;
            end
        end
    end

    int aw_hs = 0, w_hs = 0, ar_hs = 0, acc_cyc = 0;
    bit proto = 0, seen = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;

    task automatic clear_mon();
        aw_hs = 0; w_hs = 0; ar_hs = 0; proto = 0; seen = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    endtask

    // Monitor: protocol tracking and scoreboard pop on each new response.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (awvalid && awready) begin
                aw_hs++;
                if (exp_q.size() > 0) begin
                    check("awaddr", awaddr, exp_q[0].addr);
                    check("awprot", awprot, exp_q[0].prot);
                end
            end
            if (wvalid && wready) begin
                w_hs++;
                if (exp_q.size() > 0) begin
                    check("wdata", wdata, exp_q[0].wd);
                    check("wstrb", wstrb, exp_q[0].strb);
                end
            end
            if (arvalid && arready) begin
                ar_hs++;
                if (exp_q.size() > 0) begin
                    check("araddr", araddr, exp_q[0].addr);
                    check("arprot", arprot, exp_q[0].prot);
                end
            end
            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) proto = 1;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata)) proto = 1;
            if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) proto = 1;
            if (bready && (awvalid || wvalid)) proto = 1;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            if (rsp_valid && !seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: got response, required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_write", rsp_write, mon_e.wr);
                    check("rsp_rdata", rsp_rdata, mon_e.rd);
                    check("rsp_resp", rsp_resp, mon_e.resp);
                    check("err_count", err_count, mon_e.err);
                    check("err_count2", err_count2, mon_e.err2);
                    check("aw_hs", aw_hs, mon_e.wr ? 1 : 0);
                    check("w_hs", w_hs, mon_e.wr ? 1 : 0);
                    check("ar_hs", ar_hs, mon_e.wr ? 0 : 1);
                    check("protocol", proto, 0);
                    if (mon_e.lat >= 0) check("latency", cyc - acc_cyc, mon_e.lat);
                    aw_hs = 0; w_hs = 0; ar_hs = 0; proto = 0;
                end
            end else if (!rsp_valid) begin
                seen = 0;
            end
        end
    end

    task automatic issue(bit wr, logic [31:0] addr, logic [31:0] d,
                         logic [3:0] strb, logic [2:0] prot,
                         logic [31:0] exp_rd, logic [1:0] exp_resp, int lat);
        exp_t e;
        int n;
        if (exp_resp != OKAY) begin
            if (exp_err < 65535) exp_err++;
            if (exp_err2 < 3) exp_err2++;
        end
        e = '{wr, addr, d, strb, prot, exp_rd, exp_resp, exp_err, exp_err2, lat};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = d; cmd_wstrb = strb; cmd_prot = prot;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL cmd_timeout: cmd_ready 0, required 1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic collect(int hold, logic [31:0] exp_rd);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: rsp_valid 0, required 1");
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_cmd_ready", cmd_ready, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1;
        @(posedge clk);
        #1;
        rsp_ready = 0;
        check("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; cmd_prot = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 0);
        check("rst_err", err_count, 0);
        check("rst_payload", {awaddr, wdata, wstrb, awprot}, 0);
        rst = 0;

        issue(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, OKAY, 3);
        collect(0, 32'h0);

        ar_delay = 3; r_data_cfg = 32'h1234_5678;
        issue(0, 32'h0000_0020, 32'h0, 4'h0, 3'b001, 32'h1234_5678, OKAY, 6);
        collect(0, 32'h1234_5678);
        ar_delay = 0;

        aw_delay = 2; w_delay = 0;
        issue(1, 32'h0000_0030, 32'hA5A5_A5A5, 4'h3, 3'b010, 32'h0, OKAY, 5);
        collect(0, 32'h0);
        aw_delay = 0; w_delay = 2;
        issue(1, 32'h0000_0034, 32'h5A5A_5A5A, 4'hC, 3'b100, 32'h0, OKAY, 5);
        collect(0, 32'h0);
        aw_delay = 1; w_delay = 1;
        issue(1, 32'h0000_0038, 32'h0F0F_0F0F, 4'h5, 3'b011, 32'h0, OKAY, 4);
        collect(0, 32'h0);
        aw_delay = 0; w_delay = 0;

        b_resp_cfg = SLVERR;
        issue(1, 32'h0000_0040, 32'h1111_2222, 4'hF, 3'b000, 32'h0, SLVERR, 3);
        collect(0, 32'h0);
        r_resp_cfg = DECERR; r_data_cfg = 32'hCAFE_0001;
        issue(0, 32'h0000_0044, 32'h0, 4'h0, 3'b000, 32'hCAFE_0001, DECERR, 3);
        collect(0, 32'hCAFE_0001);
        r_resp_cfg = SLVERR; r_data_cfg = 32'h0000_0002;
        issue(0, 32'h0000_0048, 32'h0, 4'h0, 3'b000, 32'h0000_0002, SLVERR, 3);
        collect(0, 32'h0000_0002);
        issue(0, 32'h0000_004C, 32'h0, 4'h0, 3'b000, 32'h0000_0002, SLVERR, 3);
        collect(0, 32'h0000_0002);
        b_resp_cfg = DECERR;
        issue(1, 32'h0000_0050, 32'h3333_4444, 4'h1, 3'b000, 32'h0, DECERR, 3);
        collect(0, 32'h0);
        b_resp_cfg = OKAY; r_resp_cfg = OKAY;

        r_data_cfg = 32'h0BAD_F00D;
        issue(0, 32'h0000_0060, 32'h0, 4'h0, 3'b000, 32'h0BAD_F00D, OKAY, 3);
        collect(4, 32'h0BAD_F00D);

        b_delay = 10;
        issue(1, 32'h0000_0070, 32'h7777_8888, 4'hF, 3'b000, 32'h0, OKAY, -1);
        n = 0;
        while (!bready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_wr_resp", bready, 1);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check("arst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_err", err_count, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        exp_err = 0; exp_err2 = 0;
        b_delay = 0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        clear_mon();
        check("post_rst_cmd_ready", cmd_ready, 1);

        r_data_cfg = 32'h1122_3344;
        issue(0, 32'h0000_0080, 32'h0, 4'h0, 3'b000, 32'h1122_3344, OKAY, 3);
        collect(0, 32'h1122_3344);

        repeat (2) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
